// File: rtl/core_pkg.sv
// Shared fetch-stage types: fetch_entry_t {pc, instr}, fetch_state_e, FETCH_DEPTH.
// Imported by fetch_fifo and fetch_stage.
package core_pkg;

  localparam int FETCH_DEPTH = 2;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    HALT
  } fetch_state_e;

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch bus bundle: imem request/response channel and decode valid/ready.
// master = fetch stage side, slave = memory/decode side.
interface fetch_stage_if;

  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_pc;
  logic [31:0] id_instr;

  modport master (
    output imem_req_valid, imem_req_addr,
    output id_valid, id_pc, id_instr,
    input  imem_req_ready, imem_rsp_valid,
    input  imem_rsp_data, id_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    input  id_valid, id_pc, id_instr,
    output imem_req_ready, imem_rsp_valid,
    output imem_rsp_data, id_ready
  );

endinterface

// File: rtl/fetch_fifo.sv
// Small in-order FIFO, parameterised on DEPTH and entry type T.
// Ports: clk, rst_n, flush (sync clear), push/din, pop/dout, count, empty.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter type T = logic [31:0]
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       push,
  input  T                           din,
  input  logic                       pop,
  output T                           dout,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  T               mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic           full;
  logic           do_push;
  logic           do_pop;

  function automatic logic [AW-1:0] nxt(
    input logic [AW-1:0] p
  );
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= nxt(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= nxt(rd_ptr);
      end
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// RV32I fetch stage: owns fetch PC, issues imem requests, buffers {pc,instr}.
// Ports: clk, rst_n, redirect_valid/pc, bus (fetch_stage_if.master), fetch_misaligned (FETCH_MISALIGN_CHK_EN).
module fetch_stage
  import core_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 redirect_valid,
  input  logic [31:0]          redirect_pc,
  fetch_stage_if.master        bus
`ifdef FETCH_MISALIGN_CHK_EN
  ,
  output logic                 fetch_misaligned
`endif
);

  fetch_state_e state;
  fetch_state_e state_nxt;

  logic [31:0]  pc_q;
  logic [31:0]  tgt;
  logic [1:0]   drop_cnt;
  logic [1:0]   out_cnt;
  logic [1:0]   fifo_cnt;
  logic         fifo_empty;
  logic         tag_empty;
  logic [31:0]  tag_pc;
  fetch_entry_t head;
  fetch_entry_t push_entry;
  logic         run;
  logic         req_fire;
  logic         rsp_fire;
  logic         push;
  logic         pop;
  logic         flush;

`ifdef FETCH_MISALIGN_CHK_EN
  assign tgt = redirect_pc;
  assign fetch_misaligned = (state == HALT);
`else
  assign tgt = redirect_pc & 32'hFFFF_FFFC;
`endif

  assign run = (state == RUN);

  // Outstanding + buffered never exceeds the FIFO depth, so every
  // response is guaranteed a slot.
  assign bus.imem_req_valid = run & ~redirect_valid &
    (({1'b0, out_cnt} + {1'b0, fifo_cnt}) < 3'd2);
  assign bus.imem_req_addr  = pc_q;

  assign req_fire = bus.imem_req_valid & bus.imem_req_ready;
  // Responses with nothing outstanding (pre-reset requests) are ignored.
  assign rsp_fire = bus.imem_rsp_valid & ~tag_empty;
  assign push     = rsp_fire & (drop_cnt == 2'd0) & run & ~redirect_valid;
  assign pop      = bus.id_valid & bus.id_ready;
  assign flush    = redirect_valid | (state == HALT);

  assign push_entry = '{pc: tag_pc, instr: bus.imem_rsp_data};

  assign bus.id_valid = ~fifo_empty & ~redirect_valid;
  assign bus.id_pc    = head.pc;
  assign bus.id_instr = head.instr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= BOOT;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      BOOT: state_nxt = RUN;
      RUN: begin
`ifdef FETCH_MISALIGN_CHK_EN
        if (redirect_valid && redirect_pc[1:0] != 2'b00) begin
          state_nxt = HALT;
        end
`endif
      end
      default: state_nxt = state;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q     <= RESET_PC;
      drop_cnt <= 2'd0;
    end else if (redirect_valid) begin
      pc_q     <= tgt;
      // Everything still in flight after this cycle is stale.
      drop_cnt <= out_cnt - {1'b0, rsp_fire};
    end else begin
      if (req_fire) begin
        pc_q <= pc_q + 32'd4;
      end
      if (rsp_fire && drop_cnt != 2'd0) begin
        drop_cnt <= drop_cnt - 2'd1;
      end
    end
  end

  fetch_fifo #(
    .DEPTH (FETCH_DEPTH),
    .T     (fetch_entry_t)
  ) u_data (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .push  (push),
    .din   (push_entry),
    .pop   (pop),
    .dout  (head),
    .count (fifo_cnt),
    .empty (fifo_empty)
  );

  // Request-PC tags; its occupancy is the outstanding-request count.
  fetch_fifo #(
    .DEPTH (FETCH_DEPTH),
    .T     (logic [31:0])
  ) u_tag (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (1'b0),
    .push  (req_fire),
    .din   (pc_q),
    .pop   (rsp_fire),
    .dout  (tag_pc),
    .count (out_cnt),
    .empty (tag_empty)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Testbench for fetch_stage: randomized imem/decode traffic vs an epoch-based model.
// Drives clk, rst_n, redirect and the fetch_stage_if slave side.
module tb_fetch_stage;
  import core_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
`ifdef FETCH_MISALIGN_CHK_EN
  logic        fetch_misaligned;
`endif

  fetch_stage_if bus ();

  fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .bus            (bus)
`ifdef FETCH_MISALIGN_CHK_EN
    ,
    .fetch_misaligned (fetch_misaligned)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          epoch;
    int          due;
  } mreq_t;

  mreq_t        memq[$];
  fetch_entry_t q[$];
  logic [31:0]  req_log[$];
  logic [31:0]  del_log[$];
  logic [31:0]  ins_log[$];
  logic [31:0]  req_cyc[$];
  logic [31:0]  del_cyc[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int epoch = 0;
  int rel_cyc = 0;
  logic [31:0] mpc = 32'h0;
  logic [31:0] nxt_pc = 32'h0;
  bit run = 0;
  bit halt = 0;

  int rdy_pct = 100;
  int idr_pct = 100;
  int rsp_pct = 100;
  int lat_max = 1;
  int redir_pct = 0;
  bit force_redir = 0;
  logic [31:0] force_pc = 32'h0;
  bit spurious = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[7:0], a[31:8]} ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [31:0] lg(input logic [31:0] qq[$], input int i);
    if (i < qq.size()) return qq[i];
    return 32'hDEAD_DEAD;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin : mdl
    logic  exp_req;
    logic  exp_idv;
    bit    hs;
    bit    pp;
    mreq_t e;
    if (!rst_n) begin
      chk("rst_req_valid", {31'b0, bus.imem_req_valid}, 32'd0);
      chk("rst_req_addr", bus.imem_req_addr, 32'h0);
      chk("rst_id_valid", {31'b0, bus.id_valid}, 32'd0);
      chk("rst_id_pc", bus.id_pc, 32'h0);
      chk("rst_id_instr", bus.id_instr, 32'h0);
`ifdef FETCH_MISALIGN_CHK_EN
      chk("rst_misaligned", {31'b0, fetch_misaligned}, 32'd0);
`endif
      memq.delete();
      q.delete();
      mpc = 32'h0;
      nxt_pc = 32'h0;
      run = 0;
      halt = 0;
      epoch++;
    end else begin
      exp_req = run & ~halt & ~redirect_valid & ((memq.size() + q.size()) < 2);
      exp_idv = (q.size() > 0) & ~redirect_valid;
      chk("req_valid", {31'b0, bus.imem_req_valid}, {31'b0, exp_req});
      if (exp_req) chk("req_addr", bus.imem_req_addr, mpc);
      chk("id_valid", {31'b0, bus.id_valid}, {31'b0, exp_idv});
      if (exp_idv) begin
        chk("id_pc", bus.id_pc, q[0].pc);
        chk("id_instr", bus.id_instr, q[0].instr);
      end
`ifdef FETCH_MISALIGN_CHK_EN
      chk("misaligned", {31'b0, fetch_misaligned}, {31'b0, halt});
`endif
      if (bus.imem_req_valid && bus.imem_req_ready) begin
        req_log.push_back(bus.imem_req_addr);
        req_cyc.push_back(cyc);
      end
      if (bus.id_valid && bus.id_ready) begin
        del_log.push_back(bus.id_pc);
        ins_log.push_back(bus.id_instr);
        del_cyc.push_back(cyc);
      end
      hs = exp_req & bus.imem_req_ready;
      pp = exp_idv & bus.id_ready;
      if (pp) begin
        chk("stream_pc", bus.id_pc, nxt_pc);
        nxt_pc = nxt_pc + 32'd4;
        void'(q.pop_front());
      end
      if (bus.imem_rsp_valid && memq.size() > 0) begin
        e = memq.pop_front();
        if (!redirect_valid && !halt && e.epoch == epoch)
          q.push_back('{pc: e.addr, instr: mem_word(e.addr)});
      end
      if (hs) begin
        memq.push_back('{addr: mpc, epoch: epoch,
                         due: cyc + $urandom_range(1, lat_max)});
        mpc = mpc + 32'd4;
      end
      if (redirect_valid) begin
        q.delete();
        epoch++;
`ifdef FETCH_MISALIGN_CHK_EN
        if (redirect_pc[1:0] != 2'b00) halt = 1;
`endif
        mpc = redirect_pc & 32'hFFFF_FFFC;
        nxt_pc = mpc;
      end
      run = 1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    redirect_valid = 1'b0;
    if (force_redir) begin
      redirect_valid = 1'b1;
      redirect_pc = force_pc;
      force_redir = 0;
    end else if ($urandom_range(0, 99) < redir_pct) begin
      redirect_valid = 1'b1;
      redirect_pc = $urandom;
`ifdef FETCH_MISALIGN_CHK_EN
      redirect_pc[1:0] = 2'b00;
`endif
    end
    bus.imem_req_ready = ($urandom_range(0, 99) < rdy_pct);
    bus.id_ready = ($urandom_range(0, 99) < idr_pct);
    if (spurious) begin
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data = 32'hBAD0_BAD0;
      spurious = 0;
    end else if (memq.size() > 0 && cyc >= memq[0].due &&
                 $urandom_range(0, 99) < rsp_pct) begin
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data = mem_word(memq[0].addr);
    end else begin
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data = $urandom;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    spurious = 1;
    step();
    rst_n = 1'b1;
    rel_cyc = cyc;
  endtask

  task automatic clear_logs();
    req_log.delete();
    del_log.delete();
    ins_log.delete();
    req_cyc.delete();
    del_cyc.delete();
  endtask

  initial begin
    bus.imem_req_ready = 1'b0;
    bus.id_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data = 32'h0;
    #1;
    do_reset();
    clear_logs();
    repeat (12) step();
    chk("boot_req0", lg(req_log, 0), 32'h0000_0000);
    chk("boot_req1", lg(req_log, 1), 32'h0000_0004);
    chk("boot_req2", lg(req_log, 2), 32'h0000_0008);
    chk("boot_req_lat", lg(req_cyc, 0) - rel_cyc, 32'd1);
    chk("boot_del_lat", lg(del_cyc, 0) - rel_cyc, 32'd3);
    chk("boot_del0", lg(del_log, 0), 32'h0000_0000);
    chk("boot_ins0", lg(ins_log, 0), 32'h1357_9BDF);
    chk("boot_del1", lg(del_log, 1), 32'h0000_0004);

    idr_pct = 0;
    repeat (5) step();
    idr_pct = 100;
    repeat (10) step();

    rsp_pct = 0;
    repeat (4) step();
    force_redir = 1;
    force_pc = 32'h0000_0100;
    rsp_pct = 100;
    step();
    clear_logs();
    repeat (10) step();
    chk("redir_req0", lg(req_log, 0), 32'h0000_0100);
    chk("redir_del0", lg(del_log, 0), 32'h0000_0100);
    chk("redir_ins0", lg(ins_log, 0), 32'h1357_9BDE);

    rdy_pct = 0;
    repeat (4) step();
    rdy_pct = 100;
    repeat (4) step();

    force_redir = 1;
    force_pc = 32'hFFFF_FFF8;
    step();
    clear_logs();
    repeat (8) step();
    chk("wrap_req0", lg(req_log, 0), 32'hFFFF_FFF8);
    chk("wrap_req1", lg(req_log, 1), 32'hFFFF_FFFC);
    chk("wrap_req2", lg(req_log, 2), 32'h0000_0000);

    rdy_pct = 70;
    idr_pct = 60;
    rsp_pct = 70;
    lat_max = 3;
    redir_pct = 5;
    repeat (600) step();
    do_reset();
    repeat (400) step();

`ifdef FETCH_MISALIGN_CHK_EN
    redir_pct = 0;
    force_redir = 1;
    force_pc = 32'h0000_0102;
    step();
    clear_logs();
    repeat (6) step();
    chk("halt_no_req", req_log.size(), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
